master_2: RTL and testbench
===========================

# master_2

Transmitting end of the valid/ready point-to-point data interface. It buffers words from a local producer in a small FIFO and presents them one at a time on `data`/`valid`. It completes each transfer only on a sampled `valid & ready` handshake, and tags every BURST_LEN-th beat with `last`. It sits directly opposite the receiving slave on the same `clk` and drives that slave's `data` and `valid` inputs.

## Interface
- DATA_W, 32: width of `in_data` and `data`.
- DEPTH, 4: FIFO depth in words; a power of two, at least 2.
- BURST_LEN, 4: number of beats per burst; at least 1.

- clk  in  1  the single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  producer word.
- in_wr  in  1  producer write strobe.
- in_full  out  1  FIFO full; a write while this is high is dropped.
- data  out  DATA_W  word presented to the receiver.
- valid  out  1  `data` holds a word not yet accepted.
- ready  in  1  receiver can accept; sampled only on the rising edge of `clk`.
- last  out  1  the current beat is the final beat of its burst.
- busy  out  1  equals `valid | !fifo_empty`.
- beat_cnt  out  16  number of completed transfers, modulo 2^16.

## Operation
- FIFO:
  - Read and write pointers are log2(DEPTH) bits each. The occupancy counter is log2(DEPTH)+1 bits.
  - `in_full` = (count == DEPTH). `fifo_empty` = (count == 0).
  - A write is accepted when `in_wr & !in_full`.
  - A write while full is ignored: no pointer or count change. A pop on the same edge does not make room for that write.
- Transfer: a transfer occurs at a rising edge where `valid & ready` = 1.
- Output stage load condition: `load = !fifo_empty & (!valid | ready)`.
  - When `load` is true: `data <= FIFO head`, `valid <= 1`, the FIFO pops, and `last <= (burst_idx == BURST_LEN-1)`. `burst_idx` then advances, wrapping to 0 after BURST_LEN-1.
  - Else if `valid & ready`: `valid <= 0`. `data` and `last` keep their values.
  - Otherwise, all outputs hold.
- Protocol rules:
  - Once `valid` is asserted, it is never deasserted without a transfer.
  - `data` and `last` are stable from the edge where `valid` rises until the transfer edge.
  - `valid` never depends combinationally on `ready`.
- Back-to-back operation: while the FIFO is non-empty and `ready` stays high, a new word loads on every transfer edge. `valid` stays high and one beat completes per cycle.
- `beat_cnt` increments by 1 at every transfer edge and wraps from 0xFFFF to 0.
- When BURST_LEN = 1, `last` is 1 on every beat.
- Same-edge write and pop:
  - Both apply at once, so the count is unchanged.
  - When the FIFO is empty there is no fall-through: a word written at edge N cannot load before edge N+1.

## Timing
- Reset (sync, `rst` = 1 at an edge) sets:
  - `valid` = 0, `data` = 0, `last` = 0.
  - `in_full` = 0, `busy` = 0, `beat_cnt` = 0.
  - `burst_idx` = 0, FIFO empty.
- Reset overrides all other activity on that edge.
  - A word in flight is discarded, even if `ready` = 1 on that edge. `beat_cnt` does not count it.
- Latency with the FIFO empty and the output idle:
  - `in_wr` at edge N puts the word in the FIFO.
  - `valid` = 1 with that word after edge N+1.
  - The earliest transfer is at edge N+2.
- Sustained throughput is one word per clock when `ready` stays high.
- `ready` is a registered input from the receiver and may change on the falling edge of `clk`. Only its value at the rising edge matters.
- `in_full` and `busy` are combinational from registered state. They are updated in the cycle after the edge that changes that state.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 on consecutive edges with `ready` held at 1 -> `valid` rises one edge after the first write, `data` shows 0x11, 0x22, 0x33 on three consecutive beats, `beat_cnt` ends at 3, `busy` = 0 afterwards.
- Load 0xA5A5A5A5 with `ready` = 0 for 5 cycles, then 1 -> `valid` and `data` are constant for all 5 cycles, one transfer occurs, `valid` drops on the next edge.
- BURST_LEN = 4, write 8 words with `ready` = 1 -> `last` is 1 on beats 4 and 8 only.
- DEPTH = 4, `ready` = 0, write 6 words -> the first word loads to the output and 4 words fill the FIFO. `in_full` = 1, the 6th write is dropped, and releasing `ready` yields exactly 5 beats in order.
- Assert `rst` while `valid` = 1, `ready` = 1, and 2 words are queued -> after that edge `valid` = 0, `busy` = 0, `beat_cnt` = 0, and no stale word is presented afterwards.
- Preload `beat_cnt` to 0xFFFE (via 65534 transfers or a force), then complete 2 transfers -> `beat_cnt` reads 0xFFFF, then 0x0000.

Source files
------------

// File: rtl/master_2.sv
// Purpose : transmitting end of a valid/ready link; buffers producer words in a
//           small FIFO and presents them one at a time, tagging burst ends.
// Latency : word written at edge N is presented (valid=1) after edge N+1; one beat/clock sustained.
// Backpr. : output holds data/last while ready=0; producer sees in_full and writes while full are dropped.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   in_data, in_wr    - producer word and write strobe
//   in_full           - FIFO full (combinational from registered count)
//   data, valid, last - output beat, its valid flag and end-of-burst tag
//   ready             - receiver accept, only its rising-edge value matters
//   busy              - valid | FIFO non-empty
//   beat_cnt          - completed transfers modulo 2^16
module master_2 #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_wr,
  output logic              in_full,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              last,
  output logic              busy,
  output logic [15:0]       beat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Keep the burst index at least one bit wide so BURST_LEN = 1 still elaborates.
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(BURST_LEN - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [BW-1:0]     burst_idx_q, burst_idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [15:0]       beat_cnt_q, beat_cnt_d;

  logic fifo_empty;
  logic push;
  logic load;
  logic xfer;

  assign fifo_empty = (count_q == '0);
  assign in_full    = (count_q == FULL_CNT);
  // push uses the current full flag, so a same-edge pop never makes room for it.
  assign push       = in_wr & ~in_full;
  // The output stage only reloads from registered FIFO state: no fall-through
  // from in_data, and valid is never a combinational function of ready.
  assign load       = ~fifo_empty & (~valid_q | ready);
  assign xfer       = valid_q & ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    burst_idx_d = burst_idx_q;
    data_d      = data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    beat_cnt_d  = beat_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (load) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      data_d   = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
      last_d   = (burst_idx_q == LAST_IDX);
      burst_idx_d = (burst_idx_q == LAST_IDX) ? '0 : burst_idx_q + BW'(1);
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    case ({push, load})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (xfer) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      burst_idx_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      burst_idx_q <= burst_idx_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // Storage needs no reset; pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign data     = data_q;
  assign valid    = valid_q;
  assign last     = last_q;
  assign busy     = valid_q | ~fifo_empty;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_master_2.sv
module tb_master_2;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_wr;
  logic        in_full;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        last;
  logic        busy;
  logic [15:0] beat_cnt;

  int n_cmp;
  int n_err;

  master_2 #(.DATA_W(32), .DEPTH(4), .BURST_LEN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_wr    (in_wr),
    .in_full  (in_full),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .last     (last),
    .busy     (busy),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_wr = 1'b0; in_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    ready = 1'b0; in_wr = 1'b0; in_data = '0; rst = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_last", 32'(last), 32'd0);
    chk("rst_in_full", 32'(in_full), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);

    // Three words, ready high throughout
    ready = 1'b1;
    in_wr = 1'b1; in_data = 32'h11; tick();
    chk("t1_valid_n", 32'(valid), 32'd0);
    chk("t1_busy_n", 32'(busy), 32'd1);
    in_data = 32'h22; tick();
    chk("t1_valid_n1", 32'(valid), 32'd1);
    chk("t1_data0", data, 32'h11);
    in_data = 32'h33; tick();
    chk("t1_data1", data, 32'h22);
    chk("t1_cnt1", 32'(beat_cnt), 32'd1);
    in_wr = 1'b0; tick();
    chk("t1_data2", data, 32'h33);
    tick();
    chk("t1_valid_end", 32'(valid), 32'd0);
    chk("t1_cnt_end", 32'(beat_cnt), 32'd3);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // Single word held under backpressure
    do_reset();
    ready = 1'b0;
    in_wr = 1'b1; in_data = 32'hA5A5A5A5; tick();
    in_wr = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 32'(valid), 32'd1);
      chk("t2_hold_data", data, 32'hA5A5A5A5);
      tick();
    end
    chk("t2_cnt_before", 32'(beat_cnt), 32'd0);
    // ready changes on the falling edge, like a registered receiver output
    @(negedge clk);
    ready = 1'b1;
    tick();
    chk("t2_valid_drop", 32'(valid), 32'd0);
    chk("t2_cnt_after", 32'(beat_cnt), 32'd1);

    // Eight beats; last on beats 4 and 8 only
    do_reset();
    ready = 1'b1;
    for (int e = 0; e < 10; e++) begin
      in_wr   = (e < 8);
      in_data = 32'(e + 1);
      tick();
      if (e >= 1 && e <= 8) begin
        chk("t3_data", data, 32'(e));
        chk("t3_last", 32'(last), ((e % 4) == 0) ? 32'd1 : 32'd0);
      end
    end
    chk("t3_valid_end", 32'(valid), 32'd0);
    chk("t3_cnt_end", 32'(beat_cnt), 32'd8);

    // Fill FIFO under backpressure; sixth write dropped
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_wr = 1'b1; in_data = 32'h100 + 32'(i);
      tick();
      if (i == 4) chk("t4_full_after5", 32'(in_full), 32'd1);
    end
    in_wr = 1'b0;
    chk("t4_full_after6", 32'(in_full), 32'd1);
    chk("t4_head", data, 32'h100);
    chk("t4_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      chk("t4_drain_data", data, 32'h100 + 32'(i));
    end
    tick();
    chk("t4_valid_end", 32'(valid), 32'd0);
    chk("t4_cnt_end", 32'(beat_cnt), 32'd5);
    chk("t4_busy_end", 32'(busy), 32'd0);

    // Reset with a word in flight and two words queued
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_wr = 1'b1; in_data = 32'h200 + 32'(i);
      tick();
    end
    in_wr = 1'b0;
    chk("t5_pre_valid", 32'(valid), 32'd1);
    chk("t5_pre_data", data, 32'h200);
    ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_cnt", 32'(beat_cnt), 32'd0);
    chk("t5_data", data, 32'd0);
    tick();
    tick();
    chk("t5_no_stale_valid", 32'(valid), 32'd0);
    chk("t5_no_stale_cnt", 32'(beat_cnt), 32'd0);

    // beat_cnt wrap
    do_reset();
    ready = 1'b0;
    force dut.beat_cnt_q = 16'hFFFE;
    #1;
    release dut.beat_cnt_q;
    tick();
    chk("t6_preload", 32'(beat_cnt), 32'hFFFE);
    ready = 1'b1;
    in_wr = 1'b1; in_data = 32'h301; tick();
    in_data = 32'h302; tick();
    in_wr = 1'b0;
    chk("t6_first_data", data, 32'h301);
    tick();
    chk("t6_cnt_ffff", 32'(beat_cnt), 32'hFFFF);
    tick();
    chk("t6_cnt_wrap", 32'(beat_cnt), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
